// File: rtl/hyperbus_cfg_shadow_regs.sv
// -----------------------------------------------------------------------------
// hyperbus_cfg_shadow_regs
//
// Double-buffered Hyperbus configuration and per-chip address ranges.
// Regbus writes update only the shadow copy. A commit request is validated,
// then held pending until the PHY reports idle. At that point the whole shadow
// set is copied to the active set on a single clock edge, so the controller
// and address decoder never see a partly updated configuration.
//
// Register map (32-bit words, byte address = 4 * word index):
//   0..7       shadow config fields (latency, en_add, burst_max, rw_recovery,
//              rx_delay, tx_delay, var_lat_check, address_space)
//   8          CTRL   (write-only, reads 0): bit0 commit, bit1 lock (sticky)
//   9          STATUS bit0 pending, bit1 commit_err (W1C), bit2 locked,
//                     bit3 timeout (W1C)
//   10+2i      shadow start address of chip i
//   11+2i      shadow end address of chip i (exclusive)
//
// Ports:
//   clk_i             clock, sole domain
//   rst_i             asynchronous reset, active-high
//   reg_req_i         regbus request (addr, write, wdata, wstrb, valid)
//   reg_rsp_o         regbus response (combinational, ready always 1)
//   phy_idle_i        controller/PHY has no transfer in flight
//   cfg_o             active configuration
//   chip_rules_o      active per-chip address ranges, idx = chip number
//   cfg_update_o      one-cycle pulse in the first cycle the new set is visible
//   commit_pending_o  a commit is accepted and waiting for phy_idle_i
//
// Optional feature macro: HYPERBUS_CFG_COMMIT_TIMEOUT_EN
//   Defined: a pending commit is aborted after TimeoutCycles consecutive
//   cycles without phy_idle_i, setting STATUS.timeout.
//   Undefined: a pending commit waits indefinitely; STATUS.timeout reads 0.
// -----------------------------------------------------------------------------

package hyperbus_pkg;

    typedef struct packed {
        logic [3:0]  t_latency_access;
        logic        en_latency_additional;
        logic [15:0] t_burst_max;
        logic [3:0]  t_read_write_recovery;
        logic [3:0]  t_rx_clk_delay;
        logic [3:0]  t_tx_clk_delay;
        logic [3:0]  t_variable_latency_check;
        logic        address_space;
    } hyper_cfg_t;

    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } rule_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

    localparam hyper_cfg_t CfgReset = '{
        t_latency_access:         4'd6,
        en_latency_additional:    1'b1,
        t_burst_max:              16'd665,
        t_read_write_recovery:    4'd6,
        t_rx_clk_delay:           4'd8,
        t_tx_clk_delay:           4'd8,
        t_variable_latency_check: 4'd3,
        address_space:            1'b0
    };

endpackage

module hyperbus_cfg_shadow_regs #(
    parameter int unsigned NumChips      = 2,
    parameter logic [31:0] ChipSpace     = 32'h40_0000,
    parameter int unsigned TimeoutCycles = 1024,
    parameter type         reg_req_t     = hyperbus_pkg::reg_req_t,
    parameter type         reg_rsp_t     = hyperbus_pkg::reg_rsp_t,
    parameter type         rule_t        = hyperbus_pkg::rule_t
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  reg_req_t                  reg_req_i,
    output reg_rsp_t                  reg_rsp_o,
    input  logic                      phy_idle_i,
    output hyperbus_pkg::hyper_cfg_t  cfg_o,
    output rule_t [NumChips-1:0]      chip_rules_o,
    output logic                      cfg_update_o,
    output logic                      commit_pending_o
);

    import hyperbus_pkg::*;

    localparam int unsigned NumRegs = 2 * NumChips + 10;

    if (NumChips < 1 || TimeoutCycles < 1) begin : g_bad_params
        $error("hyperbus_cfg_shadow_regs: NumChips and TimeoutCycles must be >= 1");
    end

    typedef enum logic {
        StIdle,
        StPending
    } state_e;

    state_e      state_q, state_d;
    hyper_cfg_t  shadow_q, shadow_d, active_q;
    logic [31:0] start_q [NumChips];
    logic [31:0] start_d [NumChips];
    logic [31:0] end_q   [NumChips];
    logic [31:0] end_d   [NumChips];
    logic [31:0] act_start_q [NumChips];
    logic [31:0] act_end_q   [NumChips];
    logic        locked_q, locked_d;
    logic        commit_err_q, commit_err_d;
    logic        update_q;
    logic        copy_en;
    logic        timeout_flag;

`ifdef HYPERBUS_CFG_COMMIT_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;
    assign timeout_flag = timeout_q;
`else
    assign timeout_flag = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------------
    logic [29:0] word_idx;
    logic        mapped, is_ctrl, is_status, pending;
    logic        req_err, wr_en;
    logic        commit_req, lock_req, clr_commit_err, clr_timeout;
    logic        unused_addr_bits;

    assign word_idx         = reg_req_i.addr[31:2];
    assign unused_addr_bits = ^reg_req_i.addr[1:0];
    assign mapped           = word_idx < 30'(NumRegs);
    assign is_ctrl          = word_idx == 30'd8;
    assign is_status        = word_idx == 30'd9;
    assign pending          = state_q == StPending;

    // STATUS stays writable under lock so errors can still be acknowledged;
    // CTRL stays writable while pending so a lock can be applied.
    assign req_err = reg_req_i.valid &
                     (!mapped |
                      (reg_req_i.write & locked_q & !is_status) |
                      (reg_req_i.write & pending & !is_status & !is_ctrl));
    assign wr_en   = reg_req_i.valid & reg_req_i.write & !req_err;

    assign commit_req     = wr_en & is_ctrl   & reg_req_i.wstrb[0] & reg_req_i.wdata[0];
    assign lock_req       = wr_en & is_ctrl   & reg_req_i.wstrb[0] & reg_req_i.wdata[1];
    assign clr_commit_err = wr_en & is_status & reg_req_i.wstrb[0] & reg_req_i.wdata[1];
    assign clr_timeout    = wr_en & is_status & reg_req_i.wstrb[0] & reg_req_i.wdata[3];

    function automatic logic [31:0] merge(input logic [31:0] old_val,
                                          input logic [31:0] new_val,
                                          input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

    // ------------------------------------------------------------------------
    // Read response
    // ------------------------------------------------------------------------
    logic [31:0] rdata;

    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path through the case/if tree leaves it unassigned (no latch).
        rdata = '0;
        case (word_idx)
            30'd0: rdata = 32'(shadow_q.t_latency_access);
            30'd1: rdata = 32'(shadow_q.en_latency_additional);
            30'd2: rdata = 32'(shadow_q.t_burst_max);
            30'd3: rdata = 32'(shadow_q.t_read_write_recovery);
            30'd4: rdata = 32'(shadow_q.t_rx_clk_delay);
            30'd5: rdata = 32'(shadow_q.t_tx_clk_delay);
            30'd6: rdata = 32'(shadow_q.t_variable_latency_check);
            30'd7: rdata = 32'(shadow_q.address_space);
            30'd8: rdata = '0;
            30'd9: rdata = {28'd0, timeout_flag, locked_q, commit_err_q, pending};
            default: begin
                for (int i = 0; i < NumChips; i++) begin
                    if (word_idx == 30'(10 + 2 * i)) rdata = start_q[i];
                    if (word_idx == 30'(11 + 2 * i)) rdata = end_q[i];
                end
            end
        endcase
    end

    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.ready = 1'b1;
        reg_rsp_o.error = req_err;
        reg_rsp_o.rdata = req_err ? 32'd0 : rdata;
    end

    // ------------------------------------------------------------------------
    // Shadow register writes (fields truncated to their width after merge)
    // ------------------------------------------------------------------------
    always_comb begin
        shadow_d = shadow_q;
        start_d  = start_q;
        end_d    = end_q;
        if (wr_en) begin
            case (word_idx)
                30'd0: shadow_d.t_latency_access = 4'(merge(32'(shadow_q.t_latency_access),
                                                       reg_req_i.wdata, reg_req_i.wstrb));
                30'd1: shadow_d.en_latency_additional = 1'(merge(32'(shadow_q.en_latency_additional),
                                                       reg_req_i.wdata, reg_req_i.wstrb));
                30'd2: shadow_d.t_burst_max = 16'(merge(32'(shadow_q.t_burst_max),
                                                       reg_req_i.wdata, reg_req_i.wstrb));
                30'd3: shadow_d.t_read_write_recovery = 4'(merge(32'(shadow_q.t_read_write_recovery),
                                                       reg_req_i.wdata, reg_req_i.wstrb));
                30'd4: shadow_d.t_rx_clk_delay = 4'(merge(32'(shadow_q.t_rx_clk_delay),
                                                       reg_req_i.wdata, reg_req_i.wstrb));
                30'd5: shadow_d.t_tx_clk_delay = 4'(merge(32'(shadow_q.t_tx_clk_delay),
                                                       reg_req_i.wdata, reg_req_i.wstrb));
                30'd6: shadow_d.t_variable_latency_check = 4'(merge(32'(shadow_q.t_variable_latency_check),
                                                       reg_req_i.wdata, reg_req_i.wstrb));
                30'd7: shadow_d.address_space = 1'(merge(32'(shadow_q.address_space),
                                                       reg_req_i.wdata, reg_req_i.wstrb));
                default: begin
                    for (int i = 0; i < NumChips; i++) begin
                        if (word_idx == 30'(10 + 2 * i))
                            start_d[i] = merge(start_q[i], reg_req_i.wdata, reg_req_i.wstrb);
                        if (word_idx == 30'(11 + 2 * i))
                            end_d[i] = merge(end_q[i], reg_req_i.wdata, reg_req_i.wstrb);
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Commit FSM
    // ------------------------------------------------------------------------
    logic ranges_ok;

    always_comb begin
        ranges_ok = 1'b1;
        for (int i = 0; i < NumChips; i++) begin
            if (!(start_q[i] < end_q[i])) ranges_ok = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        copy_en      = 1'b0;
        commit_err_d = clr_commit_err ? 1'b0 : commit_err_q;
        // Commit is evaluated before the lock bit of the same write lands.
        locked_d     = locked_q | lock_req;
`ifdef HYPERBUS_CFG_COMMIT_TIMEOUT_EN
        cnt_d        = cnt_q;
        timeout_d    = clr_timeout ? 1'b0 : timeout_q;
`endif
        case (state_q)
            StIdle: begin
                if (commit_req) begin
                    if (ranges_ok) begin
                        state_d = StPending;
`ifdef HYPERBUS_CFG_COMMIT_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        commit_err_d = 1'b1;
                    end
                end
            end
            StPending: begin
                // A further commit write while pending is deliberately ignored.
                if (phy_idle_i) begin
                    copy_en = 1'b1;
                    state_d = StIdle;
                end
`ifdef HYPERBUS_CFG_COMMIT_TIMEOUT_EN
                else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

`ifndef HYPERBUS_CFG_COMMIT_TIMEOUT_EN
    logic unused_clr_timeout;
    assign unused_clr_timeout = clr_timeout;
`endif

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: the range arrays are flops, not RAM, so every entry gets
            // an explicit reset value; shadow and active start identical.
            state_q      <= StIdle;
            shadow_q     <= CfgReset;
            active_q     <= CfgReset;
            for (int i = 0; i < NumChips; i++) begin
                start_q[i]     <= ChipSpace * 32'(i);
                end_q[i]       <= ChipSpace * 32'(i + 1);
                act_start_q[i] <= ChipSpace * 32'(i);
                act_end_q[i]   <= ChipSpace * 32'(i + 1);
            end
            locked_q     <= 1'b0;
            commit_err_q <= 1'b0;
            update_q     <= 1'b0;
`ifdef HYPERBUS_CFG_COMMIT_TIMEOUT_EN
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments for all state so every flop
            // samples pre-edge values regardless of statement order.
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            start_q      <= start_d;
            end_q        <= end_d;
            locked_q     <= locked_d;
            commit_err_q <= commit_err_d;
            update_q     <= copy_en;
            // Shadow writes are blocked while pending, so shadow_q is stable.
            if (copy_en) begin
                active_q    <= shadow_q;
                act_start_q <= start_q;
                act_end_q   <= end_q;
            end
`ifdef HYPERBUS_CFG_COMMIT_TIMEOUT_EN
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign cfg_o            = active_q;
    assign cfg_update_o     = update_q;
    assign commit_pending_o = pending;

    always_comb begin
        chip_rules_o = '0;
        for (int i = 0; i < NumChips; i++) begin
            chip_rules_o[i].idx        = 32'(i);
            chip_rules_o[i].start_addr = act_start_q[i];
            chip_rules_o[i].end_addr   = act_end_q[i];
        end
    end

endmodule

// File: tb/tb_hyperbus_cfg_shadow_regs.sv
// -----------------------------------------------------------------------------
// Self-checking bench for hyperbus_cfg_shadow_regs.
// Table-driven register accesses followed by hand-written commit, error,
// lock, timeout and reset sequences. Bus expectations go through a queue.
// -----------------------------------------------------------------------------
module tb_hyperbus_cfg_shadow_regs;
    import hyperbus_pkg::*;

    localparam int NumChips = 2;
`ifdef HYPERBUS_CFG_COMMIT_TIMEOUT_EN
    localparam int TimeoutCycles = 8;
    localparam int HoldCycles    = 1;
`else
    localparam int TimeoutCycles = 1024;
    localparam int HoldCycles    = 20;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    reg_req_t                 req;
    reg_rsp_t                 rsp;
    logic                     phy_idle;
    hyper_cfg_t               cfg;
    rule_t [NumChips-1:0]     rules;
    logic                     upd;
    logic                     pend;

    hyperbus_cfg_shadow_regs #(
        .NumChips      (NumChips),
        .ChipSpace     (32'h40_0000),
        .TimeoutCycles (TimeoutCycles)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .reg_req_i        (req),
        .reg_rsp_o        (rsp),
        .phy_idle_i       (phy_idle),
        .cfg_o            (cfg),
        .chip_rules_o     (rules),
        .cfg_update_o     (upd),
        .commit_pending_o (pend)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int upd_count = 0;

    always @(negedge clk) if (upd === 1'b1) upd_count++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        bit          chk_rdata;
    } exp_t;
    exp_t exp_q[$];

    task automatic bus_op(input string name, input logic wr, input int word,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input bit chk_rd);
        exp_t e;
        exp_q.push_back('{name, exp_rdata, exp_err, chk_rd});
        @(negedge clk);
        req.valid = 1'b1;
        req.write = wr;
        req.addr  = 32'(word) << 2;
        req.wdata = wdata;
        req.wstrb = strb;
        #2;
        e = exp_q.pop_front();
        check({e.name, ".err"}, 32'(rsp.error), 32'(e.err));
        if (e.chk_rdata) check({e.name, ".rdata"}, rsp.rdata, e.rdata);
        @(posedge clk);
        #1;
        req.valid = 1'b0;
        req.write = 1'b0;
    endtask

    task automatic wr(input string name, input int word, input logic [31:0] d,
                      input logic [3:0] strb, input logic exp_err);
        bus_op(name, 1'b1, word, d, strb, 32'd0, exp_err, 1'b0);
    endtask

    task automatic rd(input string name, input int word, input logic [31:0] exp,
                      input logic exp_err);
        bus_op(name, 1'b0, word, 32'd0, 4'h0, exp, exp_err, 1'b1);
    endtask

    typedef struct {
        logic        write;
        int          word;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;
    vec_t vecs[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        req      = '0;
        phy_idle = 1'b0;
        rst      = 1'b1;

        // Reset state of outputs.
        #12;
        check("rst.pending", 32'(pend), 32'd0);
        check("rst.update", 32'(upd), 32'd0);
        check("rst.cfg.latency", 32'(cfg.t_latency_access), 32'd6);
        check("rst.cfg.en_add", 32'(cfg.en_latency_additional), 32'd1);
        check("rst.cfg.burst", 32'(cfg.t_burst_max), 32'd665);
        check("rst.cfg.rx", 32'(cfg.t_rx_clk_delay), 32'd8);
        check("rst.rule0.end", rules[0].end_addr, 32'h40_0000);
        check("rst.rule1.idx", rules[1].idx, 32'd1);
        check("rst.rule1.start", rules[1].start_addr, 32'h40_0000);
        check("rst.rule1.end", rules[1].end_addr, 32'h80_0000);
        @(negedge clk);
        rst = 1'b0;

        // Register table: reset reads, byte strobes, truncation, unmapped.
        vecs.push_back('{1'b0, 0,  32'd0, 4'h0, 32'd6,        1'b0});
        vecs.push_back('{1'b0, 1,  32'd0, 4'h0, 32'd1,        1'b0});
        vecs.push_back('{1'b0, 2,  32'd0, 4'h0, 32'd665,      1'b0});
        vecs.push_back('{1'b0, 3,  32'd0, 4'h0, 32'd6,        1'b0});
        vecs.push_back('{1'b0, 4,  32'd0, 4'h0, 32'd8,        1'b0});
        vecs.push_back('{1'b0, 5,  32'd0, 4'h0, 32'd8,        1'b0});
        vecs.push_back('{1'b0, 6,  32'd0, 4'h0, 32'd3,        1'b0});
        vecs.push_back('{1'b0, 7,  32'd0, 4'h0, 32'd0,        1'b0});
        vecs.push_back('{1'b0, 8,  32'd0, 4'h0, 32'd0,        1'b0});
        vecs.push_back('{1'b0, 9,  32'd0, 4'h0, 32'd0,        1'b0});
        vecs.push_back('{1'b0, 10, 32'd0, 4'h0, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 11, 32'd0, 4'h0, 32'h40_0000,  1'b0});
        vecs.push_back('{1'b0, 12, 32'd0, 4'h0, 32'h40_0000,  1'b0});
        vecs.push_back('{1'b0, 13, 32'd0, 4'h0, 32'h80_0000,  1'b0});
        vecs.push_back('{1'b0, 14, 32'd0, 4'h0, 32'd0,        1'b1});
        vecs.push_back('{1'b1, 0,  32'hFFFF_FF09, 4'b0001, 32'd0, 1'b0});
        vecs.push_back('{1'b0, 0,  32'd0, 4'h0, 32'd9,        1'b0});
        vecs.push_back('{1'b1, 2,  32'hAAAA_1234, 4'b0011, 32'd0, 1'b0});
        vecs.push_back('{1'b0, 2,  32'd0, 4'h0, 32'h1234,     1'b0});
        vecs.push_back('{1'b1, 0,  32'h0000_0003, 4'b0000, 32'd0, 1'b0});
        vecs.push_back('{1'b0, 0,  32'd0, 4'h0, 32'd9,        1'b0});
        vecs.push_back('{1'b1, 1,  32'h0000_00FE, 4'b1111, 32'd0, 1'b0});
        vecs.push_back('{1'b0, 1,  32'd0, 4'h0, 32'd0,        1'b0});
        vecs.push_back('{1'b1, 15, 32'h1, 4'b1111, 32'd0,     1'b1});
        for (int i = 0; i < vecs.size(); i++) begin
            bus_op($sformatf("vec%0d", i), vecs[i].write, vecs[i].word, vecs[i].wdata,
                   vecs[i].strb, vecs[i].exp_rdata, vecs[i].exp_err, !vecs[i].write);
        end

        // Commit with PHY already idle: pending for one cycle, then update.
        phy_idle = 1'b1;
        wr("commit1.ctrl", 8, 32'h1, 4'h1, 1'b0);
        check("commit1.pending", 32'(pend), 32'd1);
        check("commit1.no_upd_yet", 32'(upd), 32'd0);
        check("commit1.old_latency", 32'(cfg.t_latency_access), 32'd6);
        @(posedge clk); #1;
        check("commit1.pending_clr", 32'(pend), 32'd0);
        check("commit1.upd", 32'(upd), 32'd1);
        check("commit1.latency", 32'(cfg.t_latency_access), 32'd9);
        check("commit1.burst", 32'(cfg.t_burst_max), 32'h1234);
        check("commit1.en_add", 32'(cfg.en_latency_additional), 32'd0);
        @(posedge clk); #1;
        check("commit1.upd_pulse_end", 32'(upd), 32'd0);

        // Commit with PHY busy: shadow writes blocked, single update later.
        phy_idle = 1'b0;
        wr("busy.wr0", 0, 32'h5, 4'h1, 1'b0);
        c0 = upd_count;
        wr("busy.ctrl", 8, 32'h1, 4'h1, 1'b0);
        check("busy.pending", 32'(pend), 32'd1);
        wr("busy.wr2_blocked", 2, 32'h55, 4'hF, 1'b1);
        rd("busy.rd2", 2, 32'h1234, 1'b0);
        rd("busy.status", 9, 32'h1, 1'b0);
        wr("busy.recommit", 8, 32'h1, 4'h1, 1'b0);
        repeat (HoldCycles) @(posedge clk);
        #1;
        check("busy.still_pending", 32'(pend), 32'd1);
        check("busy.no_update", 32'(upd_count - c0), 32'd0);
        check("busy.old_latency", 32'(cfg.t_latency_access), 32'd9);
        @(negedge clk);
        phy_idle = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("busy.one_update", 32'(upd_count - c0), 32'd1);
        check("busy.latency", 32'(cfg.t_latency_access), 32'd5);
        check("busy.pending_clr", 32'(pend), 32'd0);

        // Invalid range: commit rejected with commit_err, W1C clear.
        wr("bad.end0", 11, 32'h0, 4'hF, 1'b0);
        c0 = upd_count;
        wr("bad.ctrl", 8, 32'h1, 4'h1, 1'b0);
        check("bad.not_pending", 32'(pend), 32'd0);
        rd("bad.status", 9, 32'h2, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("bad.no_update", 32'(upd_count - c0), 32'd0);
        wr("bad.w1c", 9, 32'h2, 4'h1, 1'b0);
        rd("bad.status_clr", 9, 32'h0, 1'b0);
        wr("bad.restore", 11, 32'h40_0000, 4'hF, 1'b0);

`ifdef HYPERBUS_CFG_COMMIT_TIMEOUT_EN
        // Timeout: abort after TimeoutCycles busy cycles, no copy.
        phy_idle = 1'b0;
        wr("to.wr0", 0, 32'hA, 4'h1, 1'b0);
        wr("to.ctrl", 8, 32'h1, 4'h1, 1'b0);
        repeat (TimeoutCycles - 1) @(posedge clk);
        #1;
        check("to.still_pending", 32'(pend), 32'd1);
        @(posedge clk); #1;
        check("to.aborted", 32'(pend), 32'd0);
        rd("to.status", 9, 32'h8, 1'b0);
        check("to.latency_kept", 32'(cfg.t_latency_access), 32'd5);
        wr("to.w1c", 9, 32'h8, 4'h1, 1'b0);
        rd("to.status_clr", 9, 32'h0, 1'b0);
`endif

        // Asynchronous reset in the middle of PENDING.
        phy_idle = 1'b0;
        wr("rstp.wr0", 0, 32'h7, 4'h1, 1'b0);
        wr("rstp.ctrl", 8, 32'h1, 4'h1, 1'b0);
        check("rstp.pending", 32'(pend), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rstp.pending_clr", 32'(pend), 32'd0);
        check("rstp.latency", 32'(cfg.t_latency_access), 32'd6);
        check("rstp.burst", 32'(cfg.t_burst_max), 32'd665);
        @(negedge clk);
        rst = 1'b0;
        rd("rstp.shadow0", 0, 32'd6, 1'b0);
        rd("rstp.status", 9, 32'h0, 1'b0);

        // Commit and lock together: commit proceeds, lock then blocks writes.
        wr("lock.wr0", 0, 32'hC, 4'h1, 1'b0);
        phy_idle = 1'b1;
        wr("lock.ctrl", 8, 32'h3, 4'h1, 1'b0);
        check("lock.pending", 32'(pend), 32'd1);
        rd("lock.status_pend", 9, 32'h5, 1'b0);
        check("lock.upd", 32'(upd), 32'd1);
        check("lock.latency", 32'(cfg.t_latency_access), 32'hC);
        rd("lock.status", 9, 32'h4, 1'b0);
        wr("lock.wr0_err", 0, 32'h1, 4'h1, 1'b1);
        wr("lock.ctrl_err", 8, 32'h1, 4'h1, 1'b1);
        wr("lock.range_err", 10, 32'h1, 4'hF, 1'b1);
        wr("lock.status_ok", 9, 32'h2, 4'h1, 1'b0);
        rd("lock.rd0", 0, 32'hC, 1'b0);
        rd("lock.unmapped", 2 * NumChips + 10, 32'h0, 1'b1);
        check("lock.no_commit", 32'(pend), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hyperbus_cfg_shadow_regs.md
Name: hyperbus_cfg_shadow_regs

Overview:
Parametrised successor to the Hyperbus config register file: shadow/active double-buffered config and per-chip address ranges, updated atomically.
Register writes land in shadow copies only. A commit request is validated, held pending until the PHY reports idle, then copied to the active set in one cycle.
Adds a sticky lock and status/error reporting; sits between the regbus and the Hyperbus controller/address decoder.

Parameters:
NumChips, 2, number of chip-select ranges (>=1)
ChipSpace, 32'h40_0000, default per-chip range size used for reset values
TimeoutCycles, 1024, commit-pending timeout limit (used only with optional feature)
reg_req_t, logic, regbus request type (addr, write, wdata[31:0], wstrb[3:0], valid)
reg_rsp_t, logic, regbus response type (rdata[31:0], error, ready)
rule_t, logic, address-decoder rule type (idx, start_addr, end_addr)

Ports:
clk_i  in  1  clock; sole clock domain
rst_i  in  1  asynchronous reset, active-high
reg_req_i  in  reg_req_t  regbus request
reg_rsp_o  out  reg_rsp_t  regbus response
phy_idle_i  in  1  controller/PHY has no transfer in flight
cfg_o  out  hyperbus_pkg::hyper_cfg_t  active config
chip_rules_o  out  NumChips x rule_t  active ranges; idx = i
cfg_update_o  out  1  one-cycle pulse: new active set visible this cycle
commit_pending_o  out  1  commit accepted, waiting for phy_idle_i

Behaviour:
- Map, 32-bit words, stride 4, index = addr[AW-1:2]. NumRegs = 2*NumChips+10.
- Words 0-7: shadow t_latency_access, en_latency_additional, t_burst_max, t_read_write_recovery, t_rx_clk_delay, t_tx_clk_delay, t_variable_latency_check, address_space.
- Word 8 CTRL (WO, reads 0): bit0 commit (self-clearing), bit1 lock (sticky set).
- Word 9 STATUS: bit0 pending, bit1 commit_err, bit2 locked, bit3 timeout. Bits 1 and 3 are W1C; others RO.
- Words 10+2i / 11+2i: shadow start/end of chip i.
- Response combinational; ready=1 always. Reads return shadow values; rdata=0 on error.
- error=1 when valid and: index unmapped; OR write to words 0-8 / 10+ while locked; OR write to words 0-7 / 10+ while pending. Erroring writes change nothing.
- Write data merged bytewise via wstrb; fields truncated to their width.
- Reset values, shadow and active identical:
  - latency 6, en_add 1, burst_max 665, rw_recovery 6, rx_delay 8, tx_delay 8, var_lat_check 3, address_space 0.
  - range i = [i*ChipSpace, (i+1)*ChipSpace), end non-inclusive.
  - Outputs at reset: cfg_update_o=0, commit_pending_o=0, all status bits 0.
- FSM IDLE/PENDING:
  - IDLE, commit written: if every shadow chip has start<end, go to PENDING; else set commit_err and stay IDLE.
  - PENDING with phy_idle_i=1: copy shadow to active at that edge, pulse cfg_update_o the following cycle, return to IDLE.
  - Commit with phy_idle_i already 1: goes to PENDING first. Earliest active update is 2 edges after the commit write.
  - Commit written while PENDING: ignored, no error.
- Same CTRL write with commit=1 and lock=1: commit is processed first, then lock is set. A lock does not cancel a pending commit.
- rst_i asserted at any time, including mid-PENDING: all state returns to reset values asynchronously.

Optional Feature:
HYPERBUS_CFG_COMMIT_TIMEOUT_EN:
- Defined: a counter starts at 0 on entry to PENDING. If phy_idle_i stays 0 for TimeoutCycles cycles, the commit is aborted: no copy, timeout bit set, return to IDLE.
- Undefined: no counter; PENDING waits indefinitely and STATUS bit3 reads 0.

Test Plan:
- Reset, then read words 0-7 and 10-13 -> 6,1,665,6,8,8,3,0,0x0,0x400000,0x400000,0x800000. cfg_o matches.
- Write word0=9 with wstrb=4'b0001, then CTRL=1 with phy_idle_i=1 -> commit_pending_o for 1 cycle, then cfg_update_o pulse; cfg_o.t_latency_access=9 two edges after the CTRL write.
- Hold phy_idle_i=0, commit, then write word2 -> error=1, shadow unchanged. Raise phy_idle_i after 20 cycles -> update exactly once.
- Write chip0 end=0 (start 0), commit -> STATUS=0x2, no update pulse. Write STATUS=0x2 -> STATUS=0.
- CTRL=0x3 with phy_idle_i=1 -> update occurs and STATUS.locked=1. Subsequent write to word0 or CTRL -> error=1. Read of index NumRegs -> error=1, rdata=0.
- With macro defined and TimeoutCycles=8: commit with phy_idle_i=0 held -> after 8 cycles STATUS=0x8|locked-state, cfg_o unchanged. Assert rst_i mid-PENDING -> all reset values restored.
